// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage and its write-back consumer:
// opcodes, bus field positions and the memory-side FSM states.
package mem_pkg;

    localparam int BUS_W = 74;

    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;

    // Field positions shared by exbus and membus (data slot is store data on
    // exbus and memres on membus).
    localparam int BUS_VALID   = 73;
    localparam int BUS_OP_HI   = 72;
    localparam int BUS_OP_LO   = 69;
    localparam int BUS_DST_HI  = 68;
    localparam int BUS_DST_LO  = 64;
    localparam int BUS_RES_HI  = 63;
    localparam int BUS_RES_LO  = 32;
    localparam int BUS_DATA_HI = 31;
    localparam int BUS_DATA_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

endpackage

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU/other ops straight through and runs
// loads/stores over a req/gnt/rvalid data-memory port, stalling execute meanwhile.
module mem_stage
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] exbus,
    output logic             ex_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic [BUS_W-1:0] membus
);

    state_t             state_reg, state_next;
    logic [3:0]         op_reg, op_next;
    logic [4:0]         dst_reg, dst_next;
    logic [31:0]        res_reg, res_next;
    logic [BUS_W-1:0]   membus_reg, membus_next;
    logic               req_reg, req_next;
    logic               we_reg, we_next;
    logic [31:0]        addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;

    logic               ex_valid;
    logic [3:0]         ex_op;
    logic [4:0]         ex_dst;
    logic [31:0]        ex_res;
    logic [31:0]        ex_data;

    assign ex_valid = exbus[BUS_VALID];
    assign ex_op    = exbus[BUS_OP_HI:BUS_OP_LO];
    assign ex_dst   = exbus[BUS_DST_HI:BUS_DST_LO];
    assign ex_res   = exbus[BUS_RES_HI:BUS_RES_LO];
    assign ex_data  = exbus[BUS_DATA_HI:BUS_DATA_LO];

    assign ex_ready   = (state_reg == IDLE);
    assign dmem_req   = req_reg;
    assign dmem_we    = we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = wdata_reg;
    assign membus     = membus_reg;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        dst_next    = dst_reg;
        res_next    = res_reg;
        req_next    = req_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        // Valid is a one-cycle pulse; the payload fields hold between pulses.
        membus_next            = membus_reg;
        membus_next[BUS_VALID] = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_op == OP_LW || ex_op == OP_SW) begin
                        op_next    = ex_op;
                        dst_next   = ex_dst;
                        res_next   = ex_res;
                        req_next   = 1'b1;
                        we_next    = (ex_op == OP_SW);
                        addr_next  = ex_res & ~32'h3;
                        wdata_next = ex_data;
                        state_next = REQ;
                    end else begin
                        membus_next = {1'b1, ex_op, ex_dst, ex_res, 32'h0};
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    req_next = 1'b0;
                    if (op_reg == OP_SW) begin
                        membus_next = {1'b1, op_reg, dst_reg, res_reg, 32'h0};
                        state_next  = IDLE;
                    end else begin
                        state_next  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    membus_next = {1'b1, op_reg, dst_reg, res_reg, dmem_rdata};
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            op_reg     <= 4'h0;
            dst_reg    <= 5'h0;
            res_reg    <= 32'h0;
            membus_reg <= '0;
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= 32'h0;
            wdata_reg  <= 32'h0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            dst_reg    <= dst_next;
            res_reg    <= res_next;
            membus_reg <= membus_next;
            req_reg    <= req_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written corner
// sequences, and randomized instructions against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [73:0] exbus;
    logic        ex_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [73:0] membus;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_model [int unsigned];

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  dst;
        logic [31:0] res;
        logic [31:0] data;
        logic [73:0] exp;
    } vec_t;

    vec_t vecs [5];

    mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .exbus      (exbus),
        .ex_ready   (ex_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .membus     (membus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] dst,
                         input logic [31:0] res, input logic [31:0] data);
        exbus = {v, op, dst, res, data};
    endtask

    function automatic logic [73:0] pulse(input logic [3:0] op, input logic [4:0] dst,
                                          input logic [31:0] res, input logic [31:0] d);
        return {1'b1, op, dst, res, d};
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] word);
        if (mem_model.exists(word)) return mem_model[word];
        return word ^ 32'h5A5A_0000;
    endfunction

    initial begin
        vecs[0] = '{4'b0001, 5'd3,  32'h11,        32'hAAAA, {1'b1, 4'b0001, 5'd3,  32'h11,        32'h0}};
        vecs[1] = '{4'b0001, 5'd3,  32'h22,        32'h5555, {1'b1, 4'b0001, 5'd3,  32'h22,        32'h0}};
        vecs[2] = '{4'b0111, 5'd31, 32'hFFFF_FFFF, 32'h1,    {1'b1, 4'b0111, 5'd31, 32'hFFFF_FFFF, 32'h0}};
        vecs[3] = '{4'b1010, 5'd5,  32'h80,        32'h7,    {1'b1, 4'b1010, 5'd5,  32'h80,        32'h0}};
        vecs[4] = '{4'b1111, 5'd0,  32'h123,       32'h9,    {1'b1, 4'b1111, 5'd0,  32'h123,       32'h0}};

        reset       = 1'b0;
        exbus       = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        tick();
        tick();
        chk("reset_membus", membus, 74'h0);
        chk("reset_req", dmem_req, 0);
        chk("reset_we", dmem_we, 0);
        chk("reset_addr", dmem_addr, 0);
        chk("reset_wdata", dmem_wdata, 0);
        chk("reset_ex_ready", ex_ready, 1);
        reset = 1'b1;
        tick();

        // Back-to-back ALU and pass-through ops from the table.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].dst, vecs[i].res, vecs[i].data);
            tick();
            chk($sformatf("vec%0d_membus", i), membus, vecs[i].exp);
            chk($sformatf("vec%0d_ex_ready", i), ex_ready, 1);
            chk($sformatf("vec%0d_no_req", i), dmem_req, 0);
        end
        drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
        tick();
        chk("idle_valid_low", membus[73], 0);
        chk("idle_fields_hold", membus[72:0], vecs[4].exp[72:0]);

        // SW with grant delayed 3 cycles.
        drive(1'b1, 4'b1001, 5'd0, 32'h1003, 32'hCAFE);
        tick();
        drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sw_req_c%0d", i), dmem_req, 1);
            chk($sformatf("sw_we_c%0d", i), dmem_we, 1);
            chk($sformatf("sw_addr_c%0d", i), dmem_addr, 32'h1000);
            chk($sformatf("sw_wdata_c%0d", i), dmem_wdata, 32'hCAFE);
            chk($sformatf("sw_ex_ready_c%0d", i), ex_ready, 0);
            chk($sformatf("sw_no_pulse_c%0d", i), membus[73], 0);
            if (i == 3) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        chk("sw_membus", membus, pulse(4'b1001, 5'd0, 32'h1003, 32'h0));
        chk("sw_ex_ready", ex_ready, 1);
        chk("sw_req_drop", dmem_req, 0);
        tick();
        chk("sw_single_pulse", membus[73], 0);

        // LW with immediate grant and rvalid two cycles later.
        drive(1'b1, 4'b1000, 5'd7, 32'h40, 32'h0);
        tick();
        drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
        chk("lw_req", dmem_req, 1);
        chk("lw_we", dmem_we, 0);
        chk("lw_addr", dmem_addr, 32'h40);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("lw_wait_no_pulse", membus[73], 0);
        chk("lw_wait_ex_ready", ex_ready, 0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        chk("lw_membus", membus, pulse(4'b1000, 5'd7, 32'h40, 32'hDEAD_BEEF));
        chk("lw_ex_ready", ex_ready, 1);

        // Spurious gnt/rvalid in IDLE.
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("spur_no_pulse_c%0d", i), membus[73], 0);
            chk($sformatf("spur_hold_c%0d", i), membus[72:0],
                pulse(4'b1000, 5'd7, 32'h40, 32'hDEAD_BEEF) & {1'b0, {73{1'b1}}});
            chk($sformatf("spur_ex_ready_c%0d", i), ex_ready, 1);
            chk($sformatf("spur_no_req_c%0d", i), dmem_req, 0);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;

        // Reset while a store request is pending: request drops at once.
        drive(1'b1, 4'b1001, 5'd2, 32'h200, 32'h77);
        tick();
        drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
        chk("rstreq_req_before", dmem_req, 1);
        reset = 1'b0;
        #1;
        chk("rstreq_req_drop", dmem_req, 0);
        chk("rstreq_ex_ready", ex_ready, 1);
        tick();
        reset = 1'b1;
        tick();

        // Reset during WAIT: no late emission, next ALU op completes.
        drive(1'b1, 4'b1000, 5'd9, 32'h300, 32'h0);
        tick();
        drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rstwait_in_wait", ex_ready, 0);
        reset = 1'b0;
        #1;
        chk("rstwait_req", dmem_req, 0);
        chk("rstwait_membus", membus, 74'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0_BAD0;
        tick();
        reset = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstwait_no_pulse", membus[73], 0);
        drive(1'b1, 4'b0010, 5'd4, 32'h55, 32'h0);
        tick();
        drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
        chk("rstwait_alu_after", membus, pulse(4'b0010, 5'd4, 32'h55, 32'h0));

        // Randomized instruction stream against a transaction-level model.
        for (int t = 0; t < 60; t++) begin
            int          kind;
            int          gdly;
            int          rdly;
            logic [3:0]  op;
            logic [4:0]  dst;
            logic [31:0] res;
            logic [31:0] data;
            logic [31:0] word;
            logic [31:0] ld;
            kind = $urandom_range(0, 3);
            dst  = 5'($urandom_range(0, 31));
            res  = 32'h100 + 32'($urandom_range(0, 63));
            data = $urandom;
            word = res - (res % 4);
            case (kind)
                0:       op = 4'($urandom_range(0, 7));
                1:       op = 4'($urandom_range(10, 15));
                2:       op = 4'b1000;
                default: op = 4'b1001;
            endcase
            chk($sformatf("rnd%0d_ready", t), ex_ready, 1);
            drive(1'b1, op, dst, res, data);
            tick();
            drive(1'b0, 4'h0, 5'h0, 32'h0, 32'h0);
            if (kind < 2) begin
                chk($sformatf("rnd%0d_pass", t), membus, pulse(op, dst, res, 32'h0));
                chk($sformatf("rnd%0d_pass_noreq", t), dmem_req, 0);
            end else begin
                gdly = $urandom_range(0, 3);
                chk($sformatf("rnd%0d_req", t), dmem_req, 1);
                chk($sformatf("rnd%0d_we", t), dmem_we, (kind == 3));
                chk($sformatf("rnd%0d_addr", t), dmem_addr, word);
                if (kind == 3) chk($sformatf("rnd%0d_wdata", t), dmem_wdata, data);
                for (int i = 0; i < gdly; i++) begin
                    tick();
                    chk($sformatf("rnd%0d_hold_req", t), dmem_req, 1);
                    chk($sformatf("rnd%0d_hold_addr", t), dmem_addr, word);
                end
                dmem_gnt = 1'b1;
                tick();
                dmem_gnt = 1'b0;
                if (kind == 3) begin
                    mem_model[word] = data;
                    chk($sformatf("rnd%0d_sw", t), membus, pulse(op, dst, res, 32'h0));
                end else begin
                    ld   = mem_read(word);
                    rdly = $urandom_range(0, 2);
                    chk($sformatf("rnd%0d_lw_wait", t), membus[73], 0);
                    for (int i = 0; i < rdly; i++) begin
                        tick();
                        chk($sformatf("rnd%0d_lw_wait", t), membus[73], 0);
                    end
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = ld;
                    tick();
                    dmem_rvalid = 1'b0;
                    chk($sformatf("rnd%0d_lw", t), membus, pulse(op, dst, res, ld));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
